// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the conv2 dot-product engine
package conv_pkg;
  localparam int CONV2_DATA_W = 16;
  localparam int CONV2_ACC_W  = 40;
  localparam int CONV2_TAPS   = 75;
  localparam int Q_FRAC       = 8;

  typedef logic signed [CONV2_DATA_W-1:0] pix_t;
  typedef logic signed [CONV2_ACC_W-1:0]  acc_t;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, COMBINE, OUTPUT} mac_state_t;
endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - signed multiply-accumulate lane with clear and enable
module mac_lane #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o
);
  logic signed [2*DATA_W-1:0] a_ext, b_ext, prod;
  logic [ACC_W-1:0] acc_q, acc_d;

  assign a_ext = {{DATA_W{a_i[DATA_W-1]}}, a_i};
  assign b_ext = {{DATA_W{b_i[DATA_W-1]}}, b_i};
  assign prod  = a_ext * b_ext;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/conv2_dual_mac.sv
// rtl/conv2_dual_mac.sv - two-lane conv2 dot product with bias, ReLU and saturation
module conv2_dual_mac
  import conv_pkg::*;
#(
  parameter int DATA_W  = CONV2_DATA_W,
  parameter int FRAC_W  = Q_FRAC,
  parameter int ACC_W   = CONV2_ACC_W,
  parameter int TAPS    = CONV2_TAPS,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic [DATA_W-1:0] w0,
  input  logic [DATA_W-1:0] w1,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] x1,
  output logic              k_restart,
  output logic              rd_en,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] result
);
  localparam int CNT_W = $clog2((TAPS > MEM_LAT) ? TAPS : MEM_LAT) + 1;

  mac_state_t state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MEM_LAT-1:0] vpipe_q, vpipe_d;
  logic [DATA_W-1:0]  bias_q, bias_d, res_d, result_q;
  logic [ACC_W-1:0]   acc0, acc1, bias_ext, sum, s;
  logic               clr, k_restart_q, rd_en_q, busy_q, out_valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bias_d  = bias_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        bias_d  = bias;
        cnt_d   = '0;
        clr     = 1'b1;
      end
      LOAD: state_d = RUN;
      RUN: if (cnt_q == CNT_W'(TAPS-1)) begin
        state_d = FLUSH;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      FLUSH: if (cnt_q == CNT_W'(MEM_LAT-1)) begin
        state_d = COMBINE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      COMBINE: state_d = OUTPUT;
      OUTPUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data lands MEM_LAT cycles after rd_en; this pipe alone gates accumulation.
  always_comb begin
    vpipe_d    = vpipe_q;
    vpipe_d[0] = rd_en_q;
    for (int i = 1; i < MEM_LAT; i++) vpipe_d[i] = vpipe_q[i-1];
  end

  mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane0 (
    .clk(clk), .reset(reset), .clr_i(clr), .en_i(vpipe_q[MEM_LAT-1]),
    .a_i(w0), .b_i(x0), .acc_o(acc0)
  );

  mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane1 (
    .clk(clk), .reset(reset), .clr_i(clr), .en_i(vpipe_q[MEM_LAT-1]),
    .a_i(w1), .b_i(x1), .acc_o(acc1)
  );

  assign bias_ext = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q} << FRAC_W;
  assign sum      = acc0 + acc1 + bias_ext;
  assign s        = $signed(sum) >>> FRAC_W;

  always_comb begin
    res_d = s[DATA_W-1:0];
    if (s[ACC_W-1])                res_d = '0;
    else if (|s[ACC_W-2:DATA_W-1]) res_d = {1'b0, {(DATA_W-1){1'b1}}};
  end

  // The combine sum folds straight into the result register so it is ready with out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vpipe_q     <= '0;
      bias_q      <= '0;
      k_restart_q <= 1'b0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vpipe_q     <= vpipe_d;
      bias_q      <= bias_d;
      k_restart_q <= (state_d == LOAD);
      rd_en_q     <= (state_d == RUN);
      busy_q      <= (state_d != IDLE);
      out_valid_q <= (state_d == OUTPUT);
      if (state_q == COMBINE) result_q <= res_d;
    end
  end

  assign k_restart = k_restart_q;
  assign rd_en     = rd_en_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
endmodule

// File: tb/tb_conv2_dual_mac.sv
// tb/tb_conv2_dual_mac.sv - directed self-checking bench for conv2_dual_mac
module tb_conv2_dual_mac;
  localparam logic [15:0] JUNK = 16'h0300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, start2;
  logic [15:0] bias;
  logic [15:0] vw0, vx0, vw1, vx1;
  logic [15:0] w0a, x0a, w1a, x1a, w0b, x0b, w1b, x1b;
  logic        kr1, rd1, bz1, ov1, kr2, rd2, bz2, ov2;
  logic [15:0] res1, res2;
  logic        p1_q;
  logic [1:0]  p2_q;

  int tests = 0;
  int fails = 0;
  int cyc, rdc, kcnt, ovcnt, ov_first, ov_prev;

  conv2_dual_mac #(.MEM_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .bias(bias),
    .w0(w0a), .w1(w1a), .x0(x0a), .x1(x1a),
    .k_restart(kr1), .rd_en(rd1), .busy(bz1), .out_valid(ov1), .result(res1)
  );

  conv2_dual_mac #(.MEM_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .bias(bias),
    .w0(w0b), .w1(w1b), .x0(x0b), .x1(x1b),
    .k_restart(kr2), .rd_en(rd2), .busy(bz2), .out_valid(ov2), .result(res2)
  );

  // Memory model: real data only MEM_LAT cycles after rd_en, junk otherwise.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_q <= 1'b0;
      p2_q <= 2'b00;
    end else begin
      p1_q <= rd1;
      p2_q <= {p2_q[0], rd2};
    end
  end

  assign w0a = p1_q ? vw0 : JUNK;
  assign x0a = p1_q ? vx0 : JUNK;
  assign w1a = p1_q ? vw1 : JUNK;
  assign x1a = p1_q ? vx1 : JUNK;
  assign w0b = p2_q[1] ? vw0 : JUNK;
  assign x0b = p2_q[1] ? vx0 : JUNK;
  assign w1b = p2_q[1] ? vw1 : JUNK;
  assign x1b = p2_q[1] ? vx1 : JUNK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_pixel(input string tag, input bit sel, input logic [15:0] b,
                           input int exp_lat, input logic [15:0] exp_res);
    int c, r, kn, kp, op;
    logic [15:0] held;
    @(negedge clk);
    bias = b;
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start2 = 1'b0;
    bias   = 16'hDEAD;
    c = 0; r = 0; kn = 0; kp = -1; op = -1;
    while (op < 0 && c < 200) begin
      @(negedge clk);
      c++;
      if (sel ? rd2 : rd1) r++;
      if (sel ? kr2 : kr1) begin
        kn++;
        if (kp < 0) kp = c;
      end
      if (sel ? ov2 : ov1) op = c;
    end
    chk({tag, ".latency"}, op, exp_lat);
    chk({tag, ".rd_en_cycles"}, r, 75);
    chk({tag, ".k_restart_pos"}, kp, 1);
    chk({tag, ".k_restart_cnt"}, kn, 1);
    held = sel ? res2 : res1;
    chk({tag, ".result"}, held, exp_res);
    @(negedge clk);
    chk({tag, ".ov_single"}, sel ? ov2 : ov1, 0);
    chk({tag, ".busy_drop"}, sel ? bz2 : bz1, 0);
    chk({tag, ".result_held"}, sel ? res2 : res1, exp_res);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start2 = 1'b0; bias = '0;
    vw0 = '0; vx0 = '0; vw1 = '0; vx1 = '0;
    repeat (3) @(negedge clk);
    chk("rst.outputs", {kr1, rd1, bz1, ov1, kr2, rd2, bz2, ov2}, 0);
    chk("rst.result", res1, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst.outputs", {kr1, rd1, bz1, ov1, kr2, rd2, bz2, ov2}, 0);
    chk("post_rst.result2", res2, 0);

    // all ones: 150 x 1.0 saturates
    vw0 = 16'h0100; vx0 = 16'h0100; vw1 = 16'h0100; vx1 = 16'h0100;
    run_pixel("t2", 1'b0, 16'h0000, 79, 16'h7FFF);

    // lane 0 only, 75 x 0.25 + bias 1.0
    vw0 = 16'h0080; vx0 = 16'h0080; vw1 = 16'h0000; vx1 = 16'h0000;
    run_pixel("t3", 1'b0, 16'h0100, 79, 16'h13C0);

    // reset at tap 40
    vw0 = 16'h0100; vx0 = 16'h0100; vw1 = 16'h0100; vx1 = 16'h0100;
    @(negedge clk); start = 1'b1; bias = 16'h0000;
    @(posedge clk); #1 start = 1'b0;
    rdc = 0; cyc = 0;
    while (rdc < 40 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (rd1) rdc++;
    end
    chk("t1.reach_tap40", rdc, 40);
    reset = 1'b1;
    #1;
    chk("t1.abort_outputs", {kr1, rd1, bz1, ov1}, 0);
    chk("t1.abort_result", res1, 0);
    @(negedge clk); reset = 1'b0;
    ovcnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (ov1 || bz1) ovcnt++;
    end
    chk("t1.no_out_valid", ovcnt, 0);
    vw0 = 16'h0080; vx0 = 16'h0080; vw1 = 16'h0000; vx1 = 16'h0000;
    run_pixel("t1.rerun", 1'b0, 16'h0100, 79, 16'h13C0);

    // negative sum clamps to zero
    vw0 = 16'h0100; vx0 = 16'hFF00; vw1 = 16'h0000; vx1 = 16'h0000;
    run_pixel("t4", 1'b0, 16'h0000, 79, 16'h0000);

    // start held high: back-to-back pixels every 80 cycles
    vw0 = 16'h0080; vx0 = 16'h0080; vw1 = 16'h0000; vx1 = 16'h0000;
    @(negedge clk); start = 1'b1; bias = 16'h0100;
    cyc = 0; kcnt = 0; ovcnt = 0; ov_first = -1; ov_prev = -1;
    repeat (245) begin
      @(negedge clk);
      cyc++;
      if (kr1) kcnt++;
      if (ov1) begin
        ovcnt++;
        chk("t5.result", res1, 16'h13C0);
        if (ov_first < 0) ov_first = cyc;
        else chk("t5.period", cyc - ov_prev, 80);
        ov_prev = cyc;
      end
    end
    chk("t5.first_ov", ov_first, 79);
    chk("t5.k_restart_cnt", kcnt, 4);
    chk("t5.ov_cnt", ovcnt, 3);
    start = 1'b0;
    cyc = 0;
    while (bz1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5.drain", bz1, 0);

    // MEM_LAT=2 build
    vw0 = 16'h0080; vx0 = 16'h0080; vw1 = 16'h0000; vx1 = 16'h0000;
    run_pixel("t6", 1'b1, 16'h0100, 80, 16'h13C0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
